reg_file_sequencer: RTL and testbench

//   Master-side controller for the 2-read/1-write register file. It accepts one

---
 rtl/reg_file_sequencer.sv | 149 ++++++++++++++
 tb/tb_reg_file_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sequencer.sv
// Sequencer that turns one handshaked register-to-register instruction into
// a read of the 2R/1W register file, an ALU operation and a single write-back.
module reg_file_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [ADDR_W-1:0] rf_addr3,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] addr3_q, addr3_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] alu_res;
  logic              op_valid;

  assign op_valid = (op_q[5:3] == 3'b000);

  always_comb begin
    alu_res = '0;
    case (op_q[2:0])
      3'd0: alu_res = rf_rdata1 & rf_rdata2;
      3'd1: alu_res = rf_rdata1 + rf_rdata2;
      3'd2: alu_res = rf_rdata1 - rf_rdata2;
      3'd3: alu_res = rf_rdata1 | rf_rdata2;
      3'd4: alu_res = rf_rdata1 ^ rf_rdata2;
      3'd5: alu_res = ($signed(rf_rdata1) < $signed(rf_rdata2)) ? rf_rdata1 : rf_rdata2;
      3'd6: alu_res = ($signed(rf_rdata1) > $signed(rf_rdata2)) ? rf_rdata1 : rf_rdata2;
      // Negating the most-negative value wraps back to itself, which is intended.
      3'd7: alu_res = rf_rdata1[DATA_W-1] ? ({DATA_W{1'b0}} - rf_rdata1) : rf_rdata1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    addr3_d   = addr3_q;
    wait_d    = wait_q;
    result_d  = result_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          rd_d    = instr_rd;
          wait_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_EXEC;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_EXEC: begin
        if (op_valid) begin
          result_d = alu_res;
        end
        addr3_d = rd_q;
        state_d = S_WB;
      end
      S_WB: begin
        if (op_valid) begin
          retired_d = retired_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      addr3_q   <= '0;
      wait_q    <= '0;
      result_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      addr3_q   <= addr3_d;
      wait_q    <= wait_d;
      result_q  <= result_d;
      retired_q <= retired_d;
    end
  end

  // Read addresses come straight from the latched sources, so they hold between instructions.
  assign instr_ready = (state_q == S_IDLE);
  assign rf_addr1    = rs1_q;
  assign rf_addr2    = rs2_q;
  assign rf_addr3    = addr3_q;
  assign rf_wdata    = result_q;
  assign result      = result_q;
  assign done        = (state_q == S_WB);
  assign err         = (state_q == S_WB) && !op_valid;
  assign rf_we       = (state_q == S_WB) && op_valid;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer driving a behavioural 1-cycle register file
// preloaded with r1=5, r2=7, r3=0x80000000.
module tb_reg_file_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  instr_op;
  logic [4:0]  instr_rs1, instr_rs2, instr_rd;
  logic [4:0]  rf_addr1, rf_addr2, rf_addr3;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_rdata1, rf_rdata2, result;
  logic        done, err;
  logic [15:0] retired_cnt;

  logic        tb_load;
  logic [31:0] mem [32];
  logic [4:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  reg_file_sequencer #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
    .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .result(result), .done(done), .err(err), .retired_cnt(retired_cnt)
  );

  // Register file model: registered reads, write on the same edge
  always @(posedge clk) begin
    rf_rdata1 <= mem[rf_addr1];
    rf_rdata2 <= mem[rf_addr2];
    if (tb_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1] <= 32'd5;
      mem[2] <= 32'd7;
      mem[3] <= 32'h8000_0000;
    end else if (rf_we) begin
      mem[rf_addr3] <= rf_wdata;
    end
  end

  always @(negedge clk) begin
    if (rf_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = rf_addr3;
        wr_data[wr_cnt] = rf_wdata;
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rs1   = a;
    instr_rs2   = b;
    instr_rd    = d;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    int wr0;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b exp 1", instr_ready); end
    n_checks++; if (rf_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobes got we=%b done=%b err=%b exp 0", rf_we, done, err); end
    n_checks++; if (result !== 32'h0 || rf_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data got result=%h wdata=%h exp 0", result, rf_wdata); end
    n_checks++; if ({rf_addr1, rf_addr2, rf_addr3} !== 15'h0) begin n_fail++; $display("[TB] FAIL reset_addr got %h exp 0", {rf_addr1, rf_addr2, rf_addr3}); end
    n_checks++; if (retired_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_retired got %0d exp 0", retired_cnt); end
    rst_n = 1'b1;
    wr0 = wr_cnt;
    repeat (5) step();
    n_checks++; if (wr_cnt !== wr0) begin n_fail++; $display("[TB] FAIL reset_quiet got %0d writes exp 0", wr_cnt - wr0); end
    // Abort an ADD mid-flight
    issue(6'd1, 5'd1, 5'd2, 5'd9);
    step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_reset got ready=%b done=%b we=%b exp 1/0/0", instr_ready, done, rf_we); end
    n_checks++; if (rf_addr1 !== 5'd0 || rf_addr2 !== 5'd0) begin n_fail++; $display("[TB] FAIL midrun_addr got %0d,%0d exp 0,0", rf_addr1, rf_addr2); end
    step();
    rst_n = 1'b1;
    repeat (5) step();
    n_checks++; if (wr_cnt !== wr0 || mem[9] !== 32'h0) begin n_fail++; $display("[TB] FAIL midrun_nowrite got writes=%0d r9=%h exp 0,0", wr_cnt - wr0, mem[9]); end
  endtask

  task automatic test_add();
    issue(6'd1, 5'd1, 5'd2, 5'd4);
    n_checks++; if (instr_ready !== 1'b0 || rf_addr1 !== 5'd1 || rf_addr2 !== 5'd2) begin n_fail++; $display("[TB] FAIL add_read got ready=%b a1=%0d a2=%0d exp 0,1,2", instr_ready, rf_addr1, rf_addr2); end
    step();
    n_checks++; if (done !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL add_exec got done=%b we=%b exp 0,0", done, rf_we); end
    step();
    n_checks++; if (rf_we !== 1'b1 || done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL add_wb_strobes got we=%b done=%b err=%b exp 1,1,0", rf_we, done, err); end
    n_checks++; if (rf_addr3 !== 5'd4 || rf_wdata !== 32'd12) begin n_fail++; $display("[TB] FAIL add_wb_data got addr3=%0d wdata=%h exp 4,0000000c", rf_addr3, rf_wdata); end
    step();
    n_checks++; if (retired_cnt !== 16'd1 || instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL add_after got retired=%0d ready=%b exp 1,1", retired_cnt, instr_ready); end
    n_checks++; if (mem[4] !== 32'd12 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL add_r4 got r4=%h done=%b exp 0000000c,0", mem[4], done); end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops [12] = '{6'd2, 6'd7, 6'd5, 6'd0, 6'd3, 6'd4, 6'd6, 6'd7, 6'd5, 6'd6, 6'd2, 6'd1};
    logic [4:0]  s1  [12] = '{5'd0, 5'd3, 5'd3, 5'd1, 5'd1, 5'd1, 5'd3, 5'd5, 5'd1, 5'd5, 5'd2, 5'd4};
    logic [4:0]  s2  [12] = '{5'd1, 5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1, 5'd0, 5'd2, 5'd1, 5'd1, 5'd0};
    logic [4:0]  dst [12] = '{5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};
    logic [31:0] exp [12] = '{32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd7, 32'd2,
                              32'd5, 32'd5, 32'd5, 32'd5, 32'd2, 32'd12};
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], s1[i], s2[i], dst[i]);
      step();
      step();
      n_checks++; if (rf_we !== 1'b1 || done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL alu%0d_strobes got we=%b done=%b err=%b exp 1,1,0", i, rf_we, done, err); end
      n_checks++; if (rf_addr3 !== dst[i] || rf_wdata !== exp[i]) begin n_fail++; $display("[TB] FAIL alu%0d_wb got addr3=%0d wdata=%h exp %0d,%h", i, rf_addr3, rf_wdata, dst[i], exp[i]); end
      step();
      n_checks++; if (mem[dst[i]] !== exp[i] || retired_cnt !== 16'(i + 2)) begin n_fail++; $display("[TB] FAIL alu%0d_after got r=%h retired=%0d exp %h,%0d", i, mem[dst[i]], retired_cnt, exp[i], i + 2); end
    end
  endtask

  task automatic test_invalid();
    int wr0;
    wr0 = wr_cnt;
    issue(6'h3F, 5'd1, 5'd2, 5'd20);
    step();
    step();
    n_checks++; if (done !== 1'b1 || err !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL invalid_strobes got done=%b err=%b we=%b exp 1,1,0", done, err, rf_we); end
    n_checks++; if (result !== 32'd12) begin n_fail++; $display("[TB] FAIL invalid_result got %h exp 0000000c", result); end
    step();
    n_checks++; if (retired_cnt !== 16'd13 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL invalid_after got retired=%0d err=%b exp 13,0", retired_cnt, err); end
    n_checks++; if (wr_cnt !== wr0 || mem[20] !== 32'h0) begin n_fail++; $display("[TB] FAIL invalid_nowrite got writes=%0d r20=%h exp 0,0", wr_cnt - wr0, mem[20]); end
  endtask

  task automatic test_back_to_back();
    int wr0;
    wr0 = wr_cnt;
    instr_valid = 1'b1;
    instr_op = 6'd1; instr_rs1 = 5'd1; instr_rs2 = 5'd2; instr_rd = 5'd21;
    step();
    instr_op = 6'd2; instr_rs1 = 5'd2; instr_rs2 = 5'd1; instr_rd = 5'd22;
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy%0d got ready=%b exp 0", c, instr_ready); end
      step();
    end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready4 got %b exp 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    n_checks++; if (instr_ready !== 1'b0 || rf_addr1 !== 5'd2) begin n_fail++; $display("[TB] FAIL b2b_second_accept got ready=%b a1=%0d exp 0,2", instr_ready, rf_addr1); end
    repeat (3) step();
    n_checks++; if (wr_cnt !== wr0 + 2) begin n_fail++; $display("[TB] FAIL b2b_count got %0d writes exp 2", wr_cnt - wr0); end
    else begin
      n_checks++; if (wr_addr[wr0] !== 5'd21 || wr_data[wr0] !== 32'd12) begin n_fail++; $display("[TB] FAIL b2b_first got %0d/%h exp 21/0000000c", wr_addr[wr0], wr_data[wr0]); end
      n_checks++; if (wr_addr[wr0+1] !== 5'd22 || wr_data[wr0+1] !== 32'd2) begin n_fail++; $display("[TB] FAIL b2b_second got %0d/%h exp 22/00000002", wr_addr[wr0+1], wr_data[wr0+1]); end
    end
  endtask

  task automatic test_exec_reset();
    int wr0, d0;
    wr0 = wr_cnt;
    d0  = done_cnt;
    issue(6'd1, 5'd1, 5'd2, 5'd6);
    step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1 || retired_cnt !== 16'd0 || result !== 32'h0) begin n_fail++; $display("[TB] FAIL exec_reset got ready=%b retired=%0d result=%h exp 1,0,0", instr_ready, retired_cnt, result); end
    step();
    rst_n = 1'b1;
    repeat (5) step();
    n_checks++; if (done_cnt !== d0 || wr_cnt !== wr0) begin n_fail++; $display("[TB] FAIL exec_reset_quiet got done=%0d writes=%0d exp 0,0", done_cnt - d0, wr_cnt - wr0); end
    n_checks++; if (mem[6] !== 32'h0 || instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL exec_reset_r6 got r6=%h ready=%b exp 0,1", mem[6], instr_ready); end
  endtask

  initial begin
    rst_n       = 1'b0;
    tb_load     = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 6'd0;
    instr_rs1   = 5'd0;
    instr_rs2   = 5'd0;
    instr_rd    = 5'd0;
    repeat (2) step();
    tb_load = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_invalid();
    test_back_to_back();
    test_exec_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
